// File: rtl/fp_encode_pipe.sv
// Three-stage valid/ready pipeline converting two's-complement samples to a
// packed {sign, exponent, significand} float code with rounding and saturation.
module fp_encode_pipe #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned SIG_W = 4,
  parameter int unsigned ROUND = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIG_W+2**EXP_W-1:0]    in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [EXP_W+SIG_W:0]         out_data,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             sat_cnt
);

  localparam int unsigned NORM_N = 2**EXP_W;
  localparam int unsigned IN_W   = SIG_W + NORM_N;
  localparam int unsigned WIN_W  = SIG_W + 1;

  // Stage 1 registers: sign-magnitude
  logic              s1_valid;
  logic              s1_sign;
  logic [IN_W-1:0]   s1_mag;
  logic              s1_force;

  // Stage 2 registers: normalised fields
  logic              s2_valid;
  logic              s2_sign;
  logic [EXP_W-1:0]  s2_exp;
  logic [SIG_W-1:0]  s2_sig;
  logic              s2_rbit;
  logic              s2_force;

  // Handshake: each stage frees up when empty or when its content moves on
  logic s1_free;
  logic s2_free;
  logic s3_free;

  always_comb begin
    s3_free = !out_valid || out_ready;
    s2_free = !s2_valid || s3_free;
    s1_free = !s1_valid || s2_free;
  end

  assign in_ready = s1_free;

  // Stage 1 combinational: sign, magnitude, most-negative detection
  logic              in_sign;
  logic [IN_W-1:0]   in_mag;
  logic              in_force;

  always_comb begin
    in_sign  = in_data[IN_W-1];
    in_mag   = in_sign ? (~in_data + IN_W'(1)) : in_data;
    in_force = in_sign && (in_data[IN_W-2:0] == '0);
  end

  // Stage 2 combinational: leading-one search; exponent equals the shift amount
  logic [EXP_W-1:0]  n_exp;
  logic [WIN_W-1:0]  n_win;

  always_comb begin
    n_exp = '0;
    for (int k = 0; k < int'(NORM_N); k++) begin
      if (s1_mag[SIG_W-1+k]) n_exp = EXP_W'(k);
    end
    // Window keeps the significand plus the bit just below it (zero when exp=0)
    n_win = WIN_W'({s1_mag, 1'b0} >> n_exp);
  end

  // Stage 3 combinational: round half up, then saturate on overflow or force
  logic [EXP_W-1:0]  r_exp;
  logic [SIG_W-1:0]  r_sig;
  logic              r_ovf;
  logic              r_sat;

  always_comb begin
    r_exp = s2_exp;
    r_sig = s2_sig;
    r_ovf = 1'b0;
    if ((ROUND != 0) && s2_rbit) begin
      if (s2_sig != '1) begin
        r_sig = s2_sig + SIG_W'(1);
      end else begin
        r_sig = {1'b1, {(SIG_W-1){1'b0}}};
        if (s2_exp == '1) r_ovf = 1'b1;
        else              r_exp = s2_exp + EXP_W'(1);
      end
    end
    r_sat = r_ovf || s2_force;
    if (r_sat) begin
      r_exp = '1;
      r_sig = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      s1_force  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_sig    <= '0;
      s2_rbit   <= 1'b0;
      s2_force  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (s1_free) s1_valid <= in_valid;
      if (s1_free && in_valid) begin
        s1_sign  <= in_sign;
        s1_mag   <= in_mag;
        s1_force <= in_force;
      end

      if (s2_free) s2_valid <= s1_valid;
      if (s2_free && s1_valid) begin
        s2_sign  <= s1_sign;
        s2_exp   <= n_exp;
        s2_sig   <= n_win[WIN_W-1:1];
        s2_rbit  <= n_win[0];
        s2_force <= s1_force;
      end

      if (s3_free) out_valid <= s2_valid;
      if (s3_free && s2_valid) begin
        out_data <= {s2_sign, r_exp, r_sig};
        out_sat  <= r_sat;
      end

      // Saturation event counter sticks at all-ones
      if (out_valid && out_ready && out_sat && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule
